irq_controller: RTL and testbench

Interrupt source side of the core's interrupt handshake. It collects external interrupt lines, prioritizes pending requests, and raises alert toward the fetch-stage next-PC logic. It holds the handler vector on pci until the fetch logic acknowledges with its one-cycle interrupt pulse. It then drives interrupt_mask high until the handler retires its return-from-interrupt, so only one interrupt is in service at a time (no nesting).

---
 rtl/irq_controller.sv | 118 +++++++++++
 tb/tb_irq_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Interrupt source: synchronizes and edge-detects irq lines, latches pending, fixed-priority select.
// Holds the handler vector and alert until the fetch ack, then masks further interrupts until reti.
module irq_controller #(
    parameter int          NUM_IRQ       = 8,
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
    parameter int          VECTOR_STRIDE = 4,
    localparam int         IDW           = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_enable,
    input  logic               global_enable,
    input  logic               interrupt,
    input  logic               reti,
    output logic               alert,
    output logic               interrupt_mask,
    output logic [31:0]        pci,
    output logic [IDW-1:0]     irq_id,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q;
    logic [NUM_IRQ-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] edge_det, eligible, ack_clr;
    logic [IDW-1:0]     irq_id_q, sel_id;
    logic [31:0]        pci_q;
    logic               alert_q, mask_q, sel_vld, ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_det = sync2_q & ~prev_q;
    assign eligible = global_enable ? (pending_q & irq_enable) : '0;
    assign ack      = (state_q == REQ) && interrupt;
    assign ack_clr  = ack ? (NUM_IRQ'(1) << irq_id_q) : '0;
    // A fresh edge on the acknowledged line overrides its clear.
    assign pending_d = (pending_q & ~ack_clr) | edge_det;

    always_comb begin
        sel_vld = 1'b0;
        sel_id  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_vld = 1'b1;
                sel_id  = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    // irq_id and pci only change on entry to REQ, so fetch sees a stable vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            alert_q  <= 1'b0;
            mask_q   <= 1'b0;
            irq_id_q <= '0;
            pci_q    <= VECTOR_BASE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        state_q  <= REQ;
                        alert_q  <= 1'b1;
                        irq_id_q <= sel_id;
                        pci_q    <= VECTOR_BASE + 32'(VECTOR_STRIDE) * 32'(sel_id);
                    end
                end
                REQ: begin
                    if (interrupt) begin
                        state_q <= SERVICE;
                        alert_q <= 1'b0;
                        mask_q  <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (reti) begin
                        state_q <= IDLE;
                        mask_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    alert_q <= 1'b0;
                    mask_q  <= 1'b0;
                end
            endcase
        end
    end

    assign alert          = alert_q;
    assign interrupt_mask = mask_q;
    assign pci            = pci_q;
    assign irq_id         = irq_id_q;
    assign pending        = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Randomized and directed bench for irq_controller against a cycle-level behavioural model.
module tb_irq_controller;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] irq_in, irq_enable;
    logic         global_enable, interrupt, reti;
    logic         alert, interrupt_mask;
    logic [31:0]  pci;
    logic [2:0]   irq_id;
    logic [N-1:0] pending;

    int errors = 0;
    int checks = 0;

    // model: m_st 0 = idle, 1 = requesting, 2 = in service
    int           m_st, m_id;
    logic [N-1:0] m_pending, h0, h1, h2;

    irq_controller #(.NUM_IRQ(N), .VECTOR_BASE(32'h100), .VECTOR_STRIDE(4)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_enable(irq_enable),
        .global_enable(global_enable), .interrupt(interrupt), .reti(reti),
        .alert(alert), .interrupt_mask(interrupt_mask), .pci(pci),
        .irq_id(irq_id), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_id = 0; m_pending = '0; h0 = '0; h1 = '0; h2 = '0;
    endtask

    // A line is seen as newly requested when the value sampled two edges ago is
    // high and the one sampled three edges ago is low.
    task automatic tick();
        logic [N-1:0] edges, elig, nxt;
        edges = h1 & ~h2;
        elig  = global_enable ? (m_pending & irq_enable) : '0;
        nxt   = m_pending;
        if (m_st == 1 && interrupt) nxt[m_id] = 1'b0;
        nxt = nxt | edges;
        case (m_st)
            0: if (elig != 0) begin
                for (int i = N - 1; i >= 0; i--) if (elig[i]) m_id = i;
                m_st = 1;
            end
            1: if (interrupt) m_st = 2;
            default: if (reti) m_st = 0;
        endcase
        m_pending = nxt;
        h2 = h1; h1 = h0; h0 = irq_in;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        irq_in = '0; irq_enable = '1; global_enable = 1'b1; interrupt = 1'b0; reti = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({alert, interrupt_mask, irq_id, pending, pci} !== {1'b0, 1'b0, 3'd0, 8'h00, 32'h100}) begin
            errors++;
            $display("FAIL reset: got a=%b m=%b id=%0d pend=%h pci=%h want 0 0 0 00 00000100",
                     alert, interrupt_mask, irq_id, pending, pci);
        end
    endtask

    task automatic test_single();
        do_reset();
        irq_in[3] = 1'b1;
        tick(); tick();
        checks++;
        if (pending !== 8'h00) begin errors++; $display("FAIL single_pend_early: got %h want 00", pending); end
        tick();
        checks++;
        if (pending !== 8'h08 || alert !== 1'b0) begin
            errors++; $display("FAIL single_pend_e2: got pend=%h a=%b want 08 0", pending, alert);
        end
        tick();
        checks++;
        if ({alert, irq_id, pci} !== {1'b1, 3'd3, 32'h10C}) begin
            errors++; $display("FAIL single_req: got a=%b id=%0d pci=%h want 1 3 0000010c", alert, irq_id, pci);
        end
        for (int i = 4; i < 8; i++) tick();
        interrupt = 1'b1; tick(); interrupt = 1'b0;
        checks++;
        if ({alert, interrupt_mask, pending} !== {1'b0, 1'b1, 8'h00}) begin
            errors++; $display("FAIL single_ack: got a=%b m=%b pend=%h want 0 1 00", alert, interrupt_mask, pending);
        end
        for (int i = 9; i < 12; i++) tick();
        checks++;
        if (interrupt_mask !== 1'b1) begin errors++; $display("FAIL single_hold_mask: got %b want 1", interrupt_mask); end
        reti = 1'b1; tick(); reti = 1'b0;
        checks++;
        if ({alert, interrupt_mask} !== 2'b00) begin
            errors++; $display("FAIL single_reti: got a=%b m=%b want 0 0", alert, interrupt_mask);
        end
    endtask

    task automatic test_priority();
        int budget;
        do_reset();
        irq_in[5] = 1'b1; irq_in[2] = 1'b1;
        budget = 0;
        tick();
        while (alert !== 1'b1 && budget < 20) begin tick(); budget++; end
        checks++;
        if ({alert, irq_id, pci} !== {1'b1, 3'd2, 32'h108}) begin
            errors++; $display("FAIL prio_first: got a=%b id=%0d pci=%h want 1 2 00000108", alert, irq_id, pci);
        end
        interrupt = 1'b1; tick(); interrupt = 1'b0;
        tick();
        reti = 1'b1; tick(); reti = 1'b0;
        checks++;
        if (alert !== 1'b0 || interrupt_mask !== 1'b0) begin
            errors++; $display("FAIL prio_idle: got a=%b m=%b want 0 0", alert, interrupt_mask);
        end
        tick();
        checks++;
        if ({alert, irq_id, pci} !== {1'b1, 3'd5, 32'h114}) begin
            errors++; $display("FAIL prio_second: got a=%b id=%0d pci=%h want 1 5 00000114", alert, irq_id, pci);
        end
    endtask

    task automatic test_masking();
        do_reset();
        global_enable = 1'b0;
        irq_in[1] = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (pending !== 8'h02 || alert !== 1'b0) begin
            errors++; $display("FAIL mask_hold: got pend=%h a=%b want 02 0", pending, alert);
        end
        global_enable = 1'b1;
        tick();
        checks++;
        if ({alert, pci} !== {1'b1, 32'h104}) begin
            errors++; $display("FAIL mask_release: got a=%b pci=%h want 1 00000104", alert, pci);
        end
    endtask

    task automatic test_no_retract();
        do_reset();
        irq_in[0] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        global_enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            irq_in = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
            checks++;
            if ({alert, pci} !== {1'b1, 32'h100}) begin
                errors++; $display("FAIL no_retract_%0d: got a=%b pci=%h want 1 00000100", i, alert, pci);
            end
        end
        interrupt = 1'b1; tick(); interrupt = 1'b0;
        checks++;
        if (alert !== 1'b0 || interrupt_mask !== 1'b1) begin
            errors++; $display("FAIL no_retract_ack: got a=%b m=%b want 0 1", alert, interrupt_mask);
        end
    endtask

    task automatic test_repend_ignored();
        do_reset();
        interrupt = 1'b1; tick(); interrupt = 1'b0;
        checks++;
        if ({alert, interrupt_mask, pending} !== {1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL int_in_idle: got a=%b m=%b pend=%h want 0 0 00", alert, interrupt_mask, pending);
        end
        irq_in[4] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        reti = 1'b1; tick(); reti = 1'b0;
        checks++;
        if ({alert, interrupt_mask, irq_id} !== {1'b1, 1'b0, 3'd4}) begin
            errors++; $display("FAIL reti_in_req: got a=%b m=%b id=%0d want 1 0 4", alert, interrupt_mask, irq_id);
        end
        irq_in[4] = 1'b0;
        tick(); tick(); tick();
        irq_in[4] = 1'b1;
        tick(); tick();
        interrupt = 1'b1; tick(); interrupt = 1'b0;
        checks++;
        if ({interrupt_mask, pending} !== {1'b1, 8'h10}) begin
            errors++; $display("FAIL repend_on_ack: got m=%b pend=%h want 1 10", interrupt_mask, pending);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        irq_in[0] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        interrupt = 1'b1; tick(); interrupt = 1'b0;
        irq_in = 8'h0B;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({interrupt_mask, pending} !== {1'b1, 8'h0A}) begin
            errors++; $display("FAIL arst_setup: got m=%b pend=%h want 1 0a", interrupt_mask, pending);
        end
        #2;
        rst_n = 1'b0;
        irq_in = '0;
        model_reset();
        #1;
        checks++;
        if ({alert, interrupt_mask, irq_id, pending, pci} !== {1'b0, 1'b0, 3'd0, 8'h00, 32'h100}) begin
            errors++; $display("FAIL arst_immediate: got a=%b m=%b id=%0d pend=%h pci=%h want 0 0 0 00 00000100",
                               alert, interrupt_mask, irq_id, pending, pci);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (alert !== 1'b0 || pending !== 8'h00) begin
            errors++; $display("FAIL arst_after: got a=%b pend=%h want 0 00", alert, pending);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            irq_in        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : irq_in;
            irq_enable    = ($urandom_range(0, 15) == 0) ? 8'($urandom) : irq_enable;
            global_enable = ($urandom_range(0, 7) != 0);
            interrupt     = ($urandom_range(0, 3) == 0);
            reti          = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if ({alert, interrupt_mask, irq_id, pending, pci} !==
                {(m_st == 1), (m_st == 2), 3'(m_id), m_pending, 32'(32'h100 + 4 * m_id)}) begin
                errors++;
                $display("FAIL random_c%0d: got a=%b m=%b id=%0d pend=%h pci=%h want a=%b m=%b id=%0d pend=%h pci=%h",
                         c, alert, interrupt_mask, irq_id, pending, pci,
                         (m_st == 1), (m_st == 2), m_id, m_pending, 32'(32'h100 + 4 * m_id));
            end
        end
        interrupt = 1'b0; reti = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_masking();
        test_no_retract();
        test_repend_ignored();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
